// File: rtl/main_memory.sv
// Byte-addressed backing store under the cache: 4-byte little-endian block reads, single-byte writes.
// Latency: ready/done assert LATENCY edges after acceptance. Backpressure: ready/done stay high until the requester drops its request.
// MEM_INIT_EN: when defined, every reset loads mem[i] = i; otherwise contents are left untouched by reset.
module main_memory #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MRead_request,
  input  logic              MWrite_request,
  input  logic [7:0]        MWrite_data,
  input  logic [ADDR_W-1:0] MAddress,
  output logic [31:0]       MRead_data,
  output logic              MRead_ready,
  output logic              MWrite_done
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, RD_DONE, WR_DONE} state_t;

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdat_q, wdat_d;
  logic [31:0]       rdat_d;
  logic              rdy_d, done_d, mem_we;
  logic [31:0]       blk_word;
  logic [7:0]        mem [DEPTH];

  // addr_q already has its low two bits cleared for reads, so the block never wraps.
  assign blk_word = {mem[{addr_q[ADDR_W-1:2], 2'd3}], mem[{addr_q[ADDR_W-1:2], 2'd2}],
                     mem[{addr_q[ADDR_W-1:2], 2'd1}], mem[{addr_q[ADDR_W-1:2], 2'd0}]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdat_d  = MRead_data;
    rdy_d   = MRead_ready;
    done_d  = MWrite_done;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MRead_request) begin
          addr_d  = {MAddress[ADDR_W-1:2], 2'b00};
          cnt_d   = CNT_INIT;
          state_d = RD_WAIT;
        end else if (MWrite_request) begin
          addr_d  = MAddress;
          wdat_d  = MWrite_data;
          cnt_d   = CNT_INIT;
          state_d = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdat_d  = blk_word;
          rdy_d   = 1'b1;
          state_d = RD_DONE;
        end
      end
      WR_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_we  = 1'b1;
          done_d  = 1'b1;
          state_d = WR_DONE;
        end
      end
      RD_DONE: begin
        if (!MRead_request) begin
          rdy_d   = 1'b0;
          state_d = IDLE;
        end
      end
      WR_DONE: begin
        if (!MWrite_request) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdat_q      <= 8'd0;
      MRead_data  <= 32'd0;
      MRead_ready <= 1'b0;
      MWrite_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
      MRead_data  <= rdat_d;
      MRead_ready <= rdy_d;
      MWrite_done <= done_d;
    end
  end

  // mem_we is only ever high from WR_WAIT, which reset forces away, so a write in flight is dropped.
`ifdef MEM_INIT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i);
    end else if (mem_we) begin
      mem[addr_q] <= wdat_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= wdat_q;
  end
`endif

`ifndef SYNTHESIS
  initial begin
    if (LATENCY < 1 || LATENCY > 15)
      $display("main_memory warning: LATENCY=%0d outside 1..15", LATENCY);
  end

  always @(posedge clk) begin
    if (rst && state_q == WR_WAIT && (MAddress !== addr_q || MWrite_data !== wdat_q))
      $display("main_memory warning: write address/data changed while write pending at %0t", $time);
  end
`endif

endmodule

// File: tb/tb_main_memory.sv
// Randomized bench for main_memory: byte-array reference model, one task per scenario.
module tb_main_memory;

  localparam int LAT0 = 4;
  localparam int LAT1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  rreq = 2'b00;
  logic [1:0]  wreq = 2'b00;
  logic [7:0]  MWrite_data = 8'd0;
  logic [7:0]  MAddress = 8'd0;
  logic [31:0] rdata0, rdata1;
  logic        rdy0, rdy1, done0, done1;

  logic [7:0]  m0 [256];
  logic [7:0]  m1 [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  main_memory #(.LATENCY(LAT0), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .MRead_request(rreq[0]), .MWrite_request(wreq[0]),
    .MWrite_data(MWrite_data), .MAddress(MAddress),
    .MRead_data(rdata0), .MRead_ready(rdy0), .MWrite_done(done0)
  );

  main_memory #(.LATENCY(LAT1), .ADDR_W(8)) dut1 (
    .clk(clk), .rst(rst),
    .MRead_request(rreq[1]), .MWrite_request(wreq[1]),
    .MWrite_data(MWrite_data), .MAddress(MAddress),
    .MRead_data(rdata1), .MRead_ready(rdy1), .MWrite_done(done1)
  );

  function automatic logic [31:0] exp0(input logic [7:0] a);
    logic [7:0] b;
    b = a & 8'hFC;
    return {m0[b + 8'd3], m0[b + 8'd2], m0[b + 8'd1], m0[b]};
  endfunction

  function automatic logic [31:0] exp1(input logic [7:0] a);
    logic [7:0] b;
    b = a & 8'hFC;
    return {m1[b + 8'd3], m1[b + 8'd2], m1[b + 8'd1], m1[b]};
  endfunction

  // Starts and ends on a falling edge; lat = edges from acceptance to ready (-1 on timeout).
  task automatic read_op(input bit u, input logic [7:0] a, output logic [31:0] d,
                         output int lat, output bit cleared);
    MAddress = a;
    rreq[u]  = 1'b1;
    lat      = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); @(negedge clk);
      if ((u ? rdy1 : rdy0) === 1'b1) begin
        lat = n - 1;
        break;
      end
    end
    d       = u ? rdata1 : rdata0;
    rreq[u] = 1'b0;
    @(posedge clk); @(negedge clk);
    cleared = ((u ? rdy1 : rdy0) === 1'b0);
  endtask

  task automatic write_op(input bit u, input logic [7:0] a, input logic [7:0] d,
                          output int lat, output bit cleared);
    MAddress    = a;
    MWrite_data = d;
    wreq[u]     = 1'b1;
    lat         = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); @(negedge clk);
      if ((u ? done1 : done0) === 1'b1) begin
        lat = n - 1;
        break;
      end
    end
    wreq[u] = 1'b0;
    @(posedge clk); @(negedge clk);
    cleared = ((u ? done1 : done0) === 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", rdy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done0); end
    checks++; if (rdata0 !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata0); end
    checks++; if (rdy1 !== 1'b0 || done1 !== 1'b0 || rdata1 !== 32'd0) begin
      errors++; $display("FAIL reset_dut1 got rdy=%b done=%b data=%h want 0/0/0", rdy1, done1, rdata1);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill;
    int lat; bit cl; logic [7:0] d;
    for (int a = 0; a < 256; a++) begin
      d = 8'($urandom);
      write_op(0, 8'(a), d, lat, cl);
      m0[a] = d;
      checks++;
      if (lat != LAT0 || !cl) begin
        errors++; $display("FAIL fill_write addr=%0h lat=%0d cleared=%b want lat=%0d cleared=1", a, lat, cl, LAT0);
      end
    end
  endtask

  task automatic test_random_rw;
    int lat; bit cl; logic [7:0] a, d; logic [31:0] got;
    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom);
        write_op(0, a, d, lat, cl);
        m0[a] = d;
        checks++;
        if (lat != LAT0 || !cl) begin
          errors++; $display("FAIL rand_write addr=%h lat=%0d cleared=%b want %0d/1", a, lat, cl, LAT0);
        end
      end else begin
        read_op(0, a, got, lat, cl);
        checks++;
        if (got !== exp0(a) || lat != LAT0 || !cl) begin
          errors++; $display("FAIL rand_read addr=%h got %h lat=%0d cl=%b want %h lat=%0d", a, got, lat, cl, exp0(a), LAT0);
        end
      end
    end
  endtask

  task automatic test_write_read;
    int lat, n_rdy; bit cl;
    write_op(0, 8'h21, 8'hAB, lat, cl);
    m0[8'h21] = 8'hAB;
    checks++;
    if (lat != LAT0 || !cl) begin errors++; $display("FAIL wr21_latency got %0d want %0d", lat, LAT0); end
    MAddress = 8'h23;
    rreq[0]  = 1'b1;
    n_rdy    = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); @(negedge clk);
      if (rdy0 === 1'b1) begin n_rdy = n - 1; break; end
    end
    checks++;
    if (n_rdy != LAT0) begin errors++; $display("FAIL rd23_latency got %0d want %0d", n_rdy, LAT0); end
    checks++;
    if (rdata0[15:8] !== 8'hAB || rdata0 !== exp0(8'h23)) begin
      errors++; $display("FAIL rd23_data got %h want %h", rdata0, exp0(8'h23));
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (rdy0 !== 1'b1) begin errors++; $display("FAIL rd23_hold cycle %0d got %b want 1", k, rdy0); end
    end
    rreq[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (rdy0 !== 1'b0) begin errors++; $display("FAIL rd23_clear got %b want 0", rdy0); end
  endtask

  task automatic test_both_high;
    logic [31:0] old, got; int n_rdy, n_done, lat; bit cl;
    old         = exp0(8'h40);
    MAddress    = 8'h41;
    MWrite_data = 8'h55;
    rreq[0]     = 1'b1;
    wreq[0]     = 1'b1;
    n_rdy       = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); @(negedge clk);
      if (rdy0 === 1'b1) begin n_rdy = n - 1; break; end
    end
    checks++;
    if (n_rdy != LAT0 || rdata0 !== old || done0 !== 1'b0) begin
      errors++; $display("FAIL both_read lat=%0d data=%h done=%b want %0d/%h/0", n_rdy, rdata0, done0, LAT0, old);
    end
    rreq[0] = 1'b0;
    n_done  = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); @(negedge clk);
      if (done0 === 1'b1) begin n_done = n; break; end
    end
    checks++;
    if (n_done != LAT0 + 2) begin errors++; $display("FAIL both_write_edges got %0d want %0d", n_done, LAT0 + 2); end
    wreq[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (done0 !== 1'b0) begin errors++; $display("FAIL both_done_clear got %b want 0", done0); end
    m0[8'h41] = 8'h55;
    read_op(0, 8'h40, got, lat, cl);
    checks++;
    if (got[15:8] !== 8'h55 || got !== exp0(8'h40)) begin
      errors++; $display("FAIL both_reread got %h want %h", got, exp0(8'h40));
    end
  endtask

  task automatic test_write_drop;
    int first, pulses, lat; bit cl; logic [31:0] got;
    MAddress    = 8'h10;
    MWrite_data = 8'h77;
    wreq[0]     = 1'b1;
    @(posedge clk); @(negedge clk);
    wreq[0] = 1'b0;
    first   = -1;
    pulses  = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); @(negedge clk);
      if (done0 === 1'b1) begin
        pulses++;
        if (first < 0) first = n;
      end
    end
    checks++;
    if (first != LAT0 || pulses != 1) begin
      errors++; $display("FAIL drop_pulse first=%0d width=%0d want %0d/1", first, pulses, LAT0);
    end
    m0[8'h10] = 8'h77;
    read_op(0, 8'h10, got, lat, cl);
    checks++;
    if (got[7:0] !== 8'h77 || got !== exp0(8'h10)) begin
      errors++; $display("FAIL drop_reread got %h want %h", got, exp0(8'h10));
    end
  endtask

  task automatic test_reset_mid;
    int lat, seen; bit cl; logic [31:0] got;
    write_op(0, 8'h80, 8'hA5, lat, cl);
    m0[8'h80] = 8'hA5;
    read_op(0, 8'h80, got, lat, cl);
    checks++;
    if (rdata0 !== exp0(8'h80)) begin errors++; $display("FAIL premid_read got %h want %h", rdata0, exp0(8'h80)); end
    MAddress = 8'h84;
    rreq[0]  = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b0;
    #1;
    checks++;
    if (rdy0 !== 1'b0 || done0 !== 1'b0 || rdata0 !== 32'd0) begin
      errors++; $display("FAIL midrd_reset got rdy=%b done=%b data=%h want 0/0/0", rdy0, done0, rdata0);
    end
    rreq[0] = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); @(negedge clk);
      if (rdy0 !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midrd_no_ready got %0d ready cycles want 0", seen); end
    MAddress    = 8'h90;
    MWrite_data = ~m0[8'h90];
    wreq[0]     = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b0;
    #1;
    checks++;
    if (done0 !== 1'b0) begin errors++; $display("FAIL midwr_reset_done got %b want 0", done0); end
    wreq[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    read_op(0, 8'h90, got, lat, cl);
    checks++;
    if (got !== exp0(8'h90) || lat != LAT0) begin
      errors++; $display("FAIL midwr_dropped got %h lat=%0d want %h lat=%0d", got, lat, exp0(8'h90), LAT0);
    end
  endtask

  task automatic test_back_to_back;
    int lat; bit cl; logic [7:0] d; logic [31:0] got;
    for (int a = 0; a < 8; a++) begin
      d = 8'($urandom);
      write_op(1, 8'(a), d, lat, cl);
      m1[a] = d;
      checks++;
      if (lat != LAT1 || !cl) begin errors++; $display("FAIL b2b_write addr=%0d lat=%0d want %0d", a, lat, LAT1); end
    end
    for (int k = 0; k < 2; k++) begin
      read_op(1, 8'(4 * k), got, lat, cl);
      checks++;
      if (got !== exp1(8'(4 * k)) || lat != LAT1 || !cl) begin
        errors++; $display("FAIL b2b_read%0d got %h lat=%0d cl=%b want %h lat=%0d", k, got, lat, cl, exp1(8'(4 * k)), LAT1);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_fill;
    test_random_rw;
    test_write_read;
    test_both_high;
    test_write_drop;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_memory.md
Name: main_memory

Overview:
- Backing store directly downstream of the direct-mapped cache. Answers the cache's memory-side request/ready handshakes.
- 256 bytes, 8-bit byte address.
- Reads return one whole 4-byte block, little-endian. Writes update one byte (write-through traffic from the cache).
- Programmable access latency models slow main memory, so the cache's miss and write paths are exercised with multi-cycle waits.

Parameters:
- LATENCY, 4, cycles from request acceptance to ready/done assertion; legal range 1..15.
- ADDR_W, 8, address width; memory depth is 2^ADDR_W bytes.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- MRead_request  input  1  block read request, level; held by requester until MRead_ready seen.
- MWrite_request  input  1  byte write request, level; held until MWrite_done seen.
- MWrite_data  input  8  byte to write; sampled at write acceptance.
- MAddress  input  ADDR_W  byte address; sampled at acceptance.
- MRead_data  output  32  block data; byte at base+k on bits [8k+7:8k].
- MRead_ready  output  1  read data valid.
- MWrite_done  output  1  write committed.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, MRead_ready=0, MWrite_done=0, MRead_data=0, latency counter=0.
  - Array contents are untouched unless MEM_INIT_EN is defined.
- States: IDLE, RD_WAIT, WR_WAIT, RD_DONE, WR_DONE.
- IDLE, on a rising edge:
  - MRead_request=1: latch base = MAddress with bits [1:0] cleared, counter <= LATENCY-1, go to RD_WAIT.
  - Otherwise, MWrite_request=1: latch MAddress and MWrite_data, counter <= LATENCY-1, go to WR_WAIT.
  - Both requests high: read wins. The write stays pending and is accepted on the first IDLE edge after the read completes.
- RD_WAIT / WR_WAIT:
  - Each edge with counter!=0 decrements the counter.
  - Edge with counter==0 completes the access. Completion therefore happens exactly LATENCY edges after the acceptance edge.
- Read completion:
  - MRead_data <= {mem[base+3], mem[base+2], mem[base+1], mem[base]}.
  - MRead_ready <= 1; go to RD_DONE.
- Write completion:
  - mem[addr] <= data; MWrite_done <= 1; go to WR_DONE.
- RD_DONE / WR_DONE:
  - Hold ready/done high while the matching request stays high.
  - On the first edge where that request is low: clear ready/done, go to IDLE.
  - A new request cannot be accepted on that same edge; the minimum gap is 1 cycle.
- Accepted operations are committed:
  - If the request drops during a WAIT state, the access still completes.
  - The write is still performed; ready/done pulses for exactly 1 cycle.
- MRead_data holds its last read value until the next read completes. It is never cleared except by reset.
- Addresses are block-aligned for reads, so there is no wrap-around. Write address uses all ADDR_W bits.
- Reset mid-access:
  - A pending write is dropped; memory is unmodified.
  - Outputs are cleared immediately, not on the next edge.
- Protocol checks (simulation only):
  - $display a warning if MAddress or MWrite_data changes while a write is in WR_WAIT.
  - $display a warning if LATENCY is outside 1..15 at time 0.

Optional Feature:
- MEM_INIT_EN defined:
  - Every reset assertion loads mem[i] = i[7:0] for all i (deterministic image).
  - Re-asserting reset restores the pattern, discarding writes.
- MEM_INIT_EN undefined:
  - Array is not reset; power-up contents are X, and data persists across reset.
  - Benches must write before reading.

Test Plan:
- MEM_INIT_EN, LATENCY=4: read request, MAddress=0x0E -> after 4 edges MRead_ready=1 and MRead_data=0x0F0E0D0C. Ready stays high until the request drops, then clears 1 cycle later.
- Write 0xAB to 0x21, then read 0x23 (LATENCY=4) -> MWrite_done 4 edges after acceptance. Read returns byte 1 = 0xAB, i.e. MRead_data[15:8]=0xAB.
- MRead_request and MWrite_request both high at IDLE (read 0x40, write 0x55 to 0x41) -> read completes first with the old byte at 0x41. Write then accepted and done. A re-read of 0x40 shows 0x55 in [15:8].
- Write request dropped 1 cycle after acceptance (0x77 to 0x10) -> MWrite_done pulses exactly 1 cycle. A subsequent read of 0x10 returns 0x77 in [7:0].
- rst low during RD_WAIT -> MRead_ready, MWrite_done and MRead_data are 0 immediately. state=IDLE, no ready pulse after rst returns high.
- LATENCY=1: back-to-back reads of 0x00 and 0x04 with a handshake-compliant requester -> each ready 1 edge after acceptance. Minimum gap of 1 idle cycle between operations.
